// File: rtl/axil_cmd_master_pkg.sv
// Shared AXI4-Lite widths, response codes and helpers for the command master.
package axil_cmd_master_pkg;

  localparam int C_AXI_ADDR_WIDTH   = 32;
  localparam int C_AXI_DATA_WIDTH   = 32;
  localparam int C_AXI_STROBE_WIDTH = C_AXI_DATA_WIDTH / 8;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

  // Counter must be able to hold the terminal value itself, and stay >= 1 bit when disabled.
  function automatic int tmo_cnt_width(input int cycles);
    return $clog2(cycles + 2);
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns read/write commands into bus transactions
// and returns each response on a registered valid/ready port.
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_AXI_STROBE_WIDTH-1:0] cmd_wstrb,

  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,

  output logic                          busy,
  output logic                          tmo,

  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_STROBE_WIDTH-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  // state   | meaning
  // IDLE    | cmd_ready high, waiting for a command
  // WR_REQ  | AW and W offered independently until both have handshaken
  // WR_RESP | BREADY high, waiting for the write response
  // RD_REQ  | ARVALID held until ARREADY
  // RD_DATA | RREADY high, waiting for read data
  // RSP     | response held on rsp_* until rsp_ready
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  localparam int             CNT_W   = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit             TMO_EN  = (TIMEOUT_CYCLES != 0);

  logic [2:0]       state;
  logic             aw_done;
  logic             w_done;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_cnt_nxt;

  logic cmd_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic in_flight;
  logic enter_rsp;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  assign cmd_hs = cmd_valid & cmd_ready & (state == S_IDLE);
  assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs   = M_AXI_BVALID & M_AXI_BREADY;
  assign ar_hs  = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs   = M_AXI_RVALID & M_AXI_RREADY;

  assign in_flight = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                     (state == S_RD_REQ) || (state == S_RD_DATA);
  assign enter_rsp = ((state == S_WR_RESP) && b_hs) || ((state == S_RD_DATA) && r_hs);

  assign tmo_cnt_nxt = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= AXI_RESP_OKAY;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_hs) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_write) begin
              state         <= S_WR_REQ;
              M_AXI_AWADDR  <= cmd_addr;
              M_AXI_WDATA   <= cmd_wdata;
              M_AXI_WSTRB   <= cmd_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
            end else begin
              state         <= S_RD_REQ;
              M_AXI_ARADDR  <= cmd_addr;
              M_AXI_ARVALID <= 1'b1;
            end
          end
        end
        S_WR_REQ: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          // Either channel may complete first; this cycle's handshakes count.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state        <= S_WR_RESP;
            M_AXI_BREADY <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (b_hs) begin
            state        <= S_RSP;
            M_AXI_BREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= M_AXI_BRESP;
          end
        end
        S_RD_REQ: begin
          if (ar_hs) begin
            state         <= S_RD_DATA;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (r_hs) begin
            state        <= S_RSP;
            M_AXI_RREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          cmd_ready     <= 1'b1;
          busy          <= 1'b0;
          M_AXI_AWVALID <= 1'b0;
          M_AXI_WVALID  <= 1'b0;
          M_AXI_BREADY  <= 1'b0;
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b0;
          rsp_valid     <= 1'b0;
        end
      endcase
    end
  end

  // Timeout is a flag only; the transaction keeps waiting on the slave.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo     <= 1'b0;
    end else if (cmd_hs) begin
      tmo_cnt <= '0;
      tmo     <= 1'b0;
    end else if (in_flight) begin
      tmo_cnt <= tmo_cnt_nxt;
      tmo     <= TMO_EN && (tmo_cnt_nxt == TMO_MAX) && !enter_rsp;
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: configurable AXI4-Lite responder plus a word-array reference model.
module tb_axil_cmd_master;
  import axil_cmd_master_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, tmo;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  always #5 clk = ~clk;

  axil_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .tmo(tmo),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid),
    .M_AXI_AWREADY(m_awready), .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
    .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready), .M_AXI_BRESP(m_bresp),
    .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready), .M_AXI_ARADDR(m_araddr),
    .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
    .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RVALID(m_rvalid),
    .M_AXI_RREADY(m_rready)
  );

  int checks = 0;
  int errors = 0;

  // Responder configuration, set by the tests between commands.
  int        cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0;
  bit        cfg_w_gate = 1'b1, cfg_b_block = 1'b0;
  logic [1:0] cfg_rresp = AXI_RESP_OKAY;

  // Responder state and bus monitor.
  int          cyc = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, awv_n = 0, wv_n = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, ar_hs_cyc = 0, r_hs_cyc = 0;
  logic        aw_taken = 1'b0, w_taken = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic [31:0] s_mem [0:63];
  logic [31:0] ref_mem [0:63];

  function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_d;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_d[8*b +: 8];
    return r;
  endfunction

  wire aw_hs = m_awvalid & m_awready;
  wire w_hs  = m_wvalid & m_wready;
  wire b_hs  = m_bvalid & m_bready;
  wire ar_hs = m_arvalid & m_arready;
  wire r_hs  = m_rvalid & m_rready;

  assign m_awready = m_awvalid && !aw_taken && (aw_cnt >= cfg_aw_wait);
  assign m_wready  = m_wvalid && !w_taken && (w_cnt >= cfg_w_wait) && (!cfg_w_gate || aw_taken);
  assign m_arready = m_arvalid && (ar_cnt >= cfg_ar_wait);
  assign m_bresp   = AXI_RESP_OKAY;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_awvalid) awv_n <= awv_n + 1;
    if (m_wvalid)  wv_n  <= wv_n + 1;
    if (aw_hs) begin aw_hs_n <= aw_hs_n + 1; aw_hs_cyc <= cyc; end
    if (w_hs)  begin w_hs_n  <= w_hs_n + 1;  w_hs_cyc  <= cyc; end
    if (b_hs)  begin b_hs_n  <= b_hs_n + 1;  b_hs_cyc  <= cyc; end
    if (ar_hs) begin ar_hs_n <= ar_hs_n + 1; ar_hs_cyc <= cyc; end
    if (r_hs)  r_hs_cyc <= cyc;
    if (rst) begin
      aw_taken <= 1'b0; w_taken <= 1'b0; m_bvalid <= 1'b0; m_rvalid <= 1'b0;
      m_rdata <= '0; m_rresp <= '0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
    end else begin
      if (aw_hs) begin aw_taken <= 1'b1; s_awaddr <= m_awaddr; aw_cnt <= 0; end
      else if (m_awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_taken <= 1'b1; s_wdata <= m_wdata; s_wstrb <= m_wstrb; w_cnt <= 0; end
      else if (m_wvalid) w_cnt <= w_cnt + 1;
      if (b_hs) begin
        m_bvalid <= 1'b0; aw_taken <= 1'b0; w_taken <= 1'b0;
        s_mem[s_awaddr[7:2]] <= merge(s_mem[s_awaddr[7:2]], s_wdata, s_wstrb);
      end else if ((aw_taken || aw_hs) && (w_taken || w_hs) && !m_bvalid && !cfg_b_block)
        m_bvalid <= 1'b1;
      if (ar_hs) begin
        m_rvalid <= 1'b1; m_rdata <= s_mem[m_araddr[7:2]]; m_rresp <= cfg_rresp; ar_cnt <= 0;
      end else if (m_arvalid) ar_cnt <= ar_cnt + 1;
      if (r_hs) m_rvalid <= 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int rdy_dly,
                        output logic [31:0] rdata, output logic [1:0] resp, output logic rwr,
                        output int acc_cyc, output int rsp_cyc);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    acc_cyc = cyc;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    rsp_cyc = cyc;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_wait: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, n);
    end
    rdata = rsp_rdata; resp = rsp_resp; rwr = rsp_write;
    repeat (rdy_dly) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_write, busy, tmo}
        !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 1000000000",
               {cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_write, busy, tmo});
    end
    checks++;
    if ({rsp_rdata, rsp_resp} !== 34'd0) begin
      errors++; $display("FAIL reset_rsp: rdata=%h resp=%b, required 0", rsp_rdata, rsp_resp);
    end
    checks++;
    if ({m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot} !== 106'd0) begin
      errors++;
      $display("FAIL reset_axi: awaddr=%h araddr=%h wdata=%h wstrb=%h prot=%b/%b, required 0",
               m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot);
    end
  endtask

  task automatic test_write_then_read();
    logic [31:0] rd; logic [1:0] rs; logic rw; int acc, rc;
    cfg_w_gate = 1'b1; cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_rresp = AXI_RESP_OKAY;
    do_cmd(1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 0, rd, rs, rw, acc, rc);
    ref_mem[5] = merge(ref_mem[5], 32'hDEADBEEF, 4'hF);
    checks++;
    if ({aw_hs_cyc - acc, w_hs_cyc - acc, b_hs_cyc - acc, rc - acc} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      errors++;
      $display("FAIL write_timing: aw/w/b/rsp at +%0d/+%0d/+%0d/+%0d, required +1/+2/+3/+4",
               aw_hs_cyc - acc, w_hs_cyc - acc, b_hs_cyc - acc, rc - acc);
    end
    checks++;
    if ({rd, rs, rw} !== {32'h0, AXI_RESP_OKAY, 1'b1}) begin
      errors++; $display("FAIL write_rsp: rdata=%h resp=%b write=%b, required 0/00/1", rd, rs, rw);
    end
    do_cmd(1'b0, 32'h14, 32'h0, 4'h0, 1, rd, rs, rw, acc, rc);
    checks++;
    if ({ar_hs_cyc - acc, r_hs_cyc - acc, rc - acc} !== {32'd1, 32'd2, 32'd3}) begin
      errors++;
      $display("FAIL read_timing: ar/r/rsp at +%0d/+%0d/+%0d, required +1/+2/+3",
               ar_hs_cyc - acc, r_hs_cyc - acc, rc - acc);
    end
    checks++;
    if ({rd, rs, rw} !== {ref_mem[5], AXI_RESP_OKAY, 1'b0}) begin
      errors++; $display("FAIL read_back: rdata=%h resp=%b write=%b, required %h/00/0", rd, rs, rw, ref_mem[5]);
    end
  endtask

  task automatic test_read_slverr();
    logic [31:0] rd; logic [1:0] rs; logic rw; int acc, rc;
    do_cmd(1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 0, rd, rs, rw, acc, rc);
    ref_mem[2] = merge(ref_mem[2], 32'hCAFEF00D, 4'hF);
    cfg_rresp = AXI_RESP_SLVERR;
    do_cmd(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, rs, rw, acc, rc);
    cfg_rresp = AXI_RESP_OKAY;
    checks++;
    if ({rd, rs, rw, rc - acc} !== {ref_mem[2], AXI_RESP_SLVERR, 1'b0, 32'd3}) begin
      errors++;
      $display("FAIL read_slverr: rdata=%h resp=%b write=%b lat=%0d, required %h/10/0/3",
               rd, rs, rw, rc - acc, ref_mem[2]);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] rd; logic [1:0] rs; logic rw; int acc, rc, awv0, wv0, b0;
    cfg_w_gate = 1'b0; cfg_aw_wait = 3; cfg_w_wait = 0;
    awv0 = awv_n; wv0 = wv_n; b0 = b_hs_n;
    do_cmd(1'b1, 32'h20, 32'h1234_5678, 4'b0101, 0, rd, rs, rw, acc, rc);
    ref_mem[8] = merge(ref_mem[8], 32'h1234_5678, 4'b0101);
    repeat (3) @(negedge clk);
    checks++;
    if ({w_hs_cyc - acc, aw_hs_cyc - acc} !== {32'd1, 32'd4}) begin
      errors++; $display("FAIL wfirst_hs: w at +%0d aw at +%0d, required +1/+4", w_hs_cyc - acc, aw_hs_cyc - acc);
    end
    checks++;
    if ({wv_n - wv0, awv_n - awv0} !== {32'd1, 32'd4}) begin
      errors++; $display("FAIL wfirst_valid: wvalid %0d cycles awvalid %0d cycles, required 1/4",
                         wv_n - wv0, awv_n - awv0);
    end
    checks++;
    if ({b_hs_n - b0, rs, rw} !== {32'd1, AXI_RESP_OKAY, 1'b1}) begin
      errors++; $display("FAIL wfirst_b: %0d B handshakes resp=%b write=%b, required 1/00/1", b_hs_n - b0, rs, rw);
    end
    cfg_w_gate = 1'b1; cfg_aw_wait = 0;
  endtask

  task automatic test_backpressure();
    logic [33:0] held; int n, rel, ar0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h14; cmd_wdata = 32'hA5A5_0F0F; cmd_wstrb = 4'b1100;
    @(negedge clk);
    cmd_valid = 1'b0;
    ref_mem[5] = merge(ref_mem[5], 32'hA5A5_0F0F, 4'b1100);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_wait: rsp_valid=%0b, required 1", rsp_valid); end
    held = {rsp_rdata, rsp_resp}; ar0 = ar_hs_n;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h14;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_write, cmd_ready, rsp_rdata, rsp_resp} !== {1'b1, 1'b1, 1'b0, held}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b write=%b cmd_ready=%b data=%h resp=%b, required 1/1/0/%h/%b",
                 i, rsp_valid, rsp_write, cmd_ready, rsp_rdata, rsp_resp, held[33:2], held[1:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (ar_hs_n !== ar0) begin errors++; $display("FAIL bp_ignored: %0d AR during hold, required 0", ar_hs_n - ar0); end
    rel = cyc; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({cyc - rel, cmd_ready, rsp_valid} !== {32'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bp_release: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({m_arvalid, cmd_ready, busy} !== 3'b101) begin
      errors++; $display("FAIL bp_accept: arvalid=%b cmd_ready=%b busy=%b, required 1/0/1", m_arvalid, cmd_ready, busy);
    end
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_write} !== {1'b1, ref_mem[5], 1'b0}) begin
      errors++; $display("FAIL bp_second: valid=%b rdata=%h write=%b, required 1/%h/0", rsp_valid, rsp_rdata, rsp_write, ref_mem[5]);
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int acc, n, first, gaps, drops, ar0; logic prev_tmo;
    cfg_ar_wait = 20;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h14;
    acc = cyc; ar0 = ar_hs_n;
    @(negedge clk);
    cmd_valid = 1'b0;
    first = -1; gaps = 0; drops = 0; prev_tmo = 1'b0; n = 0;
    while (!rsp_valid && n < 80) begin
      if (tmo && first < 0) first = cyc;
      if (first >= 0 && !tmo) gaps++;
      if (ar_hs_n == ar0 && !m_arvalid) drops++;
      prev_tmo = tmo;
      @(negedge clk); n++;
    end
    cfg_ar_wait = 0;
    checks++;
    if (first !== acc + TMO + 1) begin
      errors++; $display("FAIL tmo_rise: tmo first seen %0d cycles after accept, required %0d", first - acc, TMO + 1);
    end
    checks++;
    if ({gaps, drops} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL tmo_hold: tmo gaps=%0d arvalid drops=%0d, required 0/0", gaps, drops);
    end
    checks++;
    if ({rsp_valid, prev_tmo, tmo, rsp_rdata} !== {1'b1, 1'b1, 1'b0, ref_mem[5]}) begin
      errors++; $display("FAIL tmo_clear: valid=%b tmo_before=%b tmo=%b rdata=%h, required 1/1/0/%h",
                         rsp_valid, prev_tmo, tmo, rsp_rdata, ref_mem[5]);
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rs; logic rw; int acc, rc, n, b0;
    cfg_b_block = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h08; cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!m_bready && n < 50) begin @(negedge clk); n++; end
    b0 = b_hs_n;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_bready, busy, cmd_ready, rsp_valid, m_awvalid, m_wvalid} !== 6'b001000) begin
      errors++; $display("FAIL rst_mid: bready=%b busy=%b cmd_ready=%b rsp_valid=%b aw/w=%b%b, required 0/0/1/0/00",
                         m_bready, busy, cmd_ready, rsp_valid, m_awvalid, m_wvalid);
    end
    rst = 1'b0; cfg_b_block = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({rsp_valid, b_hs_n - b0} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL rst_drop: rsp_valid=%b B handshakes=%0d, required 0/0", rsp_valid, b_hs_n - b0);
    end
    do_cmd(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, rs, rw, acc, rc);
    checks++;
    if (rd !== ref_mem[2]) begin errors++; $display("FAIL rst_nowrite: rdata=%h, required %h", rd, ref_mem[2]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, addr; logic [1:0] rs, exp_rs; logic rw, wr; logic [3:0] s;
    int acc, rc, idx, b0, r0;
    for (int i = 16; i < 32; i++) begin
      d = $urandom;
      do_cmd(1'b1, 32'(i * 4), d, 4'hF, 0, rd, rs, rw, acc, rc);
      ref_mem[i] = d;
    end
    for (int k = 0; k < 40; k++) begin
      idx = $urandom_range(16, 31); addr = 32'(idx * 4);
      wr = 1'($urandom); d = $urandom; s = 4'($urandom);
      cfg_aw_wait = $urandom_range(0, 3); cfg_w_wait = $urandom_range(0, 3);
      cfg_ar_wait = $urandom_range(0, 3); cfg_w_gate = 1'($urandom);
      cfg_rresp = 2'($urandom);
      exp_rs = wr ? AXI_RESP_OKAY : cfg_rresp;
      b0 = b_hs_n; r0 = ar_hs_n;
      do_cmd(wr, addr, d, s, $urandom_range(0, 3), rd, rs, rw, acc, rc);
      if (wr) ref_mem[idx] = merge(ref_mem[idx], d, s);
      checks++;
      if ({rd, rs, rw} !== {(wr ? 32'h0 : ref_mem[idx]), exp_rs, wr}) begin
        errors++;
        $display("FAIL rand[%0d] %s @%h: rdata=%h resp=%b write=%b, required %h/%b/%b", k, wr ? "wr" : "rd",
                 addr, rd, rs, rw, wr ? 32'h0 : ref_mem[idx], exp_rs, wr);
      end
      checks++;
      if ({b_hs_n - b0, ar_hs_n - r0} !== (wr ? {32'd1, 32'd0} : {32'd0, 32'd1})) begin
        errors++; $display("FAIL rand_count[%0d]: B=%0d AR=%0d, required %0d/%0d", k, b_hs_n - b0, ar_hs_n - r0,
                           wr ? 1 : 0, wr ? 0 : 1);
      end
    end
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_w_gate = 1'b1; cfg_rresp = AXI_RESP_OKAY;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    test_reset();
    test_write_then_read();
    test_read_slverr();
    test_w_before_aw();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Responder memory starts at zero, matching the reference model.
  initial begin
    for (int i = 0; i < 64; i++) s_mem[i] = '0;
  end

endmodule
